// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for the shared 16:1 mux datapath.
// Grants one requester at a time, bounded by MAX_HOLD cycles while contested.
module mux_rr_arbiter #(
    parameter int unsigned N_REQ    = 16,
    parameter int unsigned SEL_W    = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] grant,
    output logic             valid
);

    localparam int unsigned       HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [SEL_W-1:0]  PTR_RST  = SEL_W'(N_REQ - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   ptr_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic [SEL_W-1:0]   win;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_nxt;
    logic [N_REQ-1:0]   grant_nxt;
    logic               valid_nxt;
    logic               any_req;
    logic               cur_req;
    logic               others;
    logic               start;
    logic               rewind;

    // In GRANT the registered one-hot grant marks the current grantee.
    assign any_req = |req;
    assign cur_req = |(req & grant);
    assign others  = |(req & ~grant);

    // Scan ptr+1, ptr+2, ... wrapping; ptr itself is examined last.
    always_comb begin
        logic             found;
        logic [SEL_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        win   = ptr;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = SEL_W'((32'(ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        rewind    = 1'b0;
        case (state)
            IDLE: begin
                if (en && any_req) begin
                    state_nxt = GRANT;
                    start     = 1'b1;
                end
            end
            GRANT: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (!cur_req) begin
                    if (any_req) begin
                        start = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (hold_cnt == HOLD_MAX) begin
                    if (others) begin
                        start = 1'b1;
                    end else begin
                        rewind = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        grant_nxt = grant;
        valid_nxt = valid;
        if (start) begin
            sel_nxt        = win;
            ptr_nxt        = win;
            hold_nxt       = HOLD_ONE;
            grant_nxt      = '0;
            grant_nxt[win] = 1'b1;
            valid_nxt      = 1'b1;
        end else if (state_nxt == IDLE) begin
            hold_nxt  = '0;
            grant_nxt = '0;
            valid_nxt = 1'b0;
        end else if (rewind) begin
            hold_nxt = HOLD_ONE;
        end else if (hold_cnt != HOLD_MAX) begin
            hold_nxt = hold_cnt + HOLD_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel      <= '0;
            grant    <= '0;
            valid    <= 1'b0;
            hold_cnt <= '0;
            ptr      <= PTR_RST;
        end else begin
            sel      <= sel_nxt;
            grant    <= grant_nxt;
            valid    <= valid_nxt;
            hold_cnt <= hold_nxt;
            ptr      <= ptr_nxt;
        end
    end

    a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
    a_valid_grant : assert property (@(posedge clk) disable iff (!rst_n)
        valid == (grant != '0));

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus a randomized
// run against a cycle model, all routed through an expected-result queue.
module tb_mux_rr_arbiter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic [15:0] req   = '0;
    logic [3:0]  sel;
    logic [15:0] grant;
    logic        valid;

    typedef struct {
        logic       v;
        logic [3:0] s;
        logic       cs;
        string      tag;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [15:0] eg;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.N_REQ(16), .SEL_W(4), .MAX_HOLD(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .req  (req),
        .sel  (sel),
        .grant(grant),
        .valid(valid)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; req = 16'hFFFF;
        q.push_back('{v: 1'b0, s: 4'd0, cs: 1'b1, tag: "reset_hold"});
        @(posedge clk); #1;
        e = q.pop_front(); eg = e.v ? (16'h1 << e.s) : 16'h0; checks++;
        if (valid !== e.v || grant !== eg || (e.cs && sel !== e.s)) begin
            errors++;
            $display("FAIL %s: got v=%0b sel=%0d grant=%h, want v=%0b sel=%0d grant=%h",
                     e.tag, valid, sel, grant, e.v, e.s, eg);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                #2 rst_n = 1'b0;
                q.push_back('{v: 1'b0, s: 4'd0, cs: 1'b1, tag: "async_reset"});
                #1;
            end else begin
                if (i == 5) rst_n = 1'b1;
                q.push_back('{v: 1'b1, s: 4'd0, cs: 1'b1,
                              tag: (i == 5) ? "regrant_after_reset" : "first_grant"});
                @(posedge clk); #1;
            end
            e = q.pop_front(); eg = e.v ? (16'h1 << e.s) : 16'h0; checks++;
            if (valid !== e.v || grant !== eg || (e.cs && sel !== e.s)) begin
                errors++;
                $display("FAIL %s: got v=%0b sel=%0d grant=%h, want v=%0b sel=%0d grant=%h",
                         e.tag, valid, sel, grant, e.v, e.s, eg);
            end
        end
        req = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_uncontested();
        en = 1'b1; req = 16'h0020;
        for (int i = 0; i < 23; i++) begin
            if (i == 22) req = '0;
            q.push_back('{v: (i != 22), s: 4'd5, cs: (i != 22), tag: "uncontested"});
            @(posedge clk); #1;
            e = q.pop_front(); eg = e.v ? (16'h1 << e.s) : 16'h0; checks++;
            if (valid !== e.v || grant !== eg || (e.cs && sel !== e.s)) begin
                errors++;
                $display("FAIL %s[%0d]: got v=%0b sel=%0d grant=%h, want v=%0b sel=%0d grant=%h",
                         e.tag, i, valid, sel, grant, e.v, e.s, eg);
            end
        end
    endtask

    task automatic test_forced_rotate();
        rst_n = 1'b0; #1 rst_n = 1'b1;
        en = 1'b1; req = 16'h8001;
        for (int c = 0; c < 33; c++) begin
            if (c == 32) req = '0;
            q.push_back('{v: (c != 32), s: (((c / 8) % 2) != 0) ? 4'd15 : 4'd0,
                          cs: (c != 32), tag: "forced_rotate"});
            @(posedge clk); #1;
            e = q.pop_front(); eg = e.v ? (16'h1 << e.s) : 16'h0; checks++;
            if (valid !== e.v || grant !== eg || (e.cs && sel !== e.s)) begin
                errors++;
                $display("FAIL %s[%0d]: got v=%0b sel=%0d grant=%h, want v=%0b sel=%0d grant=%h",
                         e.tag, c, valid, sel, grant, e.v, e.s, eg);
            end
        end
    endtask

    task automatic test_release_switch();
        logic [15:0] rv [5] = '{16'h0208, 16'h0208, 16'h0208, 16'h0200, 16'h0200};
        logic [3:0]  sv [5] = '{4'd3, 4'd3, 4'd3, 4'd9, 4'd9};
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req = rv[i];
            q.push_back('{v: 1'b1, s: sv[i], cs: 1'b1, tag: "release_switch"});
            @(posedge clk); #1;
            e = q.pop_front(); eg = e.v ? (16'h1 << e.s) : 16'h0; checks++;
            if (valid !== e.v || grant !== eg || (e.cs && sel !== e.s)) begin
                errors++;
                $display("FAIL %s[%0d]: got v=%0b sel=%0d grant=%h, want v=%0b sel=%0d grant=%h",
                         e.tag, i, valid, sel, grant, e.v, e.s, eg);
            end
        end
    endtask

    task automatic test_disable();
        logic        ev [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] rv [5] = '{16'h0200, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        logic        vv [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0]  sv [5] = '{4'd9, 4'd9, 4'd10, 4'd10, 4'd10};
        for (int i = 0; i < 5; i++) begin
            en = ev[i]; req = rv[i];
            q.push_back('{v: vv[i], s: sv[i], cs: 1'b1, tag: "disable"});
            @(posedge clk); #1;
            e = q.pop_front(); eg = e.v ? (16'h1 << e.s) : 16'h0; checks++;
            if (valid !== e.v || grant !== eg || (e.cs && sel !== e.s)) begin
                errors++;
                $display("FAIL %s[%0d]: got v=%0b sel=%0d grant=%h, want v=%0b sel=%0d grant=%h",
                         e.tag, i, valid, sel, grant, e.v, e.s, eg);
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] rv [5] = '{16'h8000, 16'h0000, 16'h0001, 16'h0001, 16'h0000};
        logic        vv [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0]  sv [5] = '{4'd15, 4'd15, 4'd0, 4'd0, 4'd0};
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req = rv[i];
            q.push_back('{v: vv[i], s: sv[i], cs: 1'b1, tag: "wrap"});
            @(posedge clk); #1;
            e = q.pop_front(); eg = e.v ? (16'h1 << e.s) : 16'h0; checks++;
            if (valid !== e.v || grant !== eg || (e.cs && sel !== e.s)) begin
                errors++;
                $display("FAIL %s[%0d]: got v=%0b sel=%0d grant=%h, want v=%0b sel=%0d grant=%h",
                         e.tag, i, valid, sel, grant, e.v, e.s, eg);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] m_sel = 4'd0;
        logic [3:0] m_ptr = 4'd15;
        logic [3:0] w;
        logic [3:0] idx;
        logic       m_st  = 1'b0;
        logic       m_v   = 1'b0;
        logic       found;
        logic       newg;
        int         m_hold = 0;
        rst_n = 1'b0; #1 rst_n = 1'b1;
        for (int c = 0; c < 400; c++) begin
            en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 5) == 0) req = 16'($urandom & $urandom & $urandom);
            found = 1'b0; w = m_ptr;
            for (int k = 1; k <= 16; k++) begin
                idx = 4'((m_ptr + k) % 16);
                if (!found && req[idx]) begin found = 1'b1; w = idx; end
            end
            newg = 1'b0;
            if (!m_st) begin
                if (en && req != 16'h0) newg = 1'b1;
            end else if (!en) begin
                m_st = 1'b0; m_v = 1'b0;
            end else if (!req[m_sel]) begin
                if (req != 16'h0) newg = 1'b1;
                else begin m_st = 1'b0; m_v = 1'b0; end
            end else if (m_hold == 8) begin
                if ((req & ~(16'h1 << m_sel)) != 16'h0) newg = 1'b1;
                else m_hold = 1;
            end else begin
                m_hold++;
            end
            if (newg) begin
                m_st = 1'b1; m_v = 1'b1; m_sel = w; m_ptr = w; m_hold = 1;
            end
            q.push_back('{v: m_v, s: m_sel, cs: 1'b1, tag: "random"});
            @(posedge clk); #1;
            e = q.pop_front(); eg = e.v ? (16'h1 << e.s) : 16'h0; checks++;
            if (valid !== e.v || grant !== eg || (e.cs && sel !== e.s)) begin
                errors++;
                $display("FAIL %s[%0d]: got v=%0b sel=%0d grant=%h, want v=%0b sel=%0d grant=%h",
                         e.tag, c, valid, sel, grant, e.v, e.s, eg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_uncontested();
        test_forced_rotate();
        test_release_switch();
        test_disable();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
